// File: rtl/addsub_nibble_seq_if.sv
// Request-side bundle of the nibble-serial add/subtract sequencer.
// The master drives a request and the slave (the sequencer) returns status and results.
interface addsub_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  logic                   start;
  logic                   op;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   result;
  logic                   cout;
  logic                   ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Wide add/subtract sequencer: drives a shared external 4-bit adder-subtractor one nibble
// per clock, LSB nibble first, and owns the operand, shadow, result and carry registers.
module addsub_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_nibble_seq_if.slave  req,
  output logic [3:0]          dp_a,
  output logic [3:0]          dp_b,
  output logic                dp_cin,
  input  logic [3:0]          dp_sum,
  input  logic                dp_cout
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            op_reg;
  logic            carry;
  logic [IdxW-1:0] idx;
  logic [W-1:0]    shadow;
  logic [W-1:0]    result_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            cout_reg;
  logic            ovf_reg;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [W-1:0]    shadow_next;

  // Select the current operand nibbles and merge the datapath sum into the shadow copy.
  always_comb begin
    a_nib       = 4'h0;
    b_nib       = 4'h0;
    shadow_next = shadow;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IdxW'(i)) begin
        a_nib                = a_reg[4*i +: 4];
        b_nib                = b_reg[4*i +: 4];
        shadow_next[4*i +: 4] = dp_sum;
      end
    end
  end

  // Datapath drive; B is pre-XORed with carry because the datapath re-inverts B by cin.
  always_comb begin
    dp_a   = 4'h0;
    dp_b   = 4'h0;
    dp_cin = 1'b0;
    if (state == StRun) begin
      dp_a   = a_nib;
      dp_b   = b_nib ^ {4{op_reg}} ^ {4{carry}};
      dp_cin = carry;
    end
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 1'b0;
      carry      <= 1'b0;
      idx        <= '0;
      shadow     <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        StIdle: begin
          if (req.start) begin
            a_reg    <= req.a;
            b_reg    <= req.b;
            op_reg   <= req.op;
            carry    <= req.op;
            idx      <= '0;
            busy_reg <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          shadow <= shadow_next;
          carry  <= dp_cout;
          if (idx == LastIdx) begin
            result_reg <= shadow_next;
            cout_reg   <= dp_cout;
            ovf_reg    <= (a_reg[W-1] == (b_reg[W-1] ^ op_reg)) &&
                          (shadow_next[W-1] != a_reg[W-1]);
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            idx        <= '0;
            state      <= StIdle;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign req.busy   = busy_reg;
  assign req.done   = done_reg;
  assign req.result = result_reg;
  assign req.cout   = cout_reg;
  assign req.ovf    = ovf_reg;

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq with NIBBLES=4 and NIBBLES=1 instances, each driving
// a behavioural 4-bit adder-subtractor that computes a + (b ^ cin) + cin.
module tb_addsub_nibble_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  addsub_nibble_seq_if #(.NIBBLES(4)) r4 ();
  addsub_nibble_seq_if #(.NIBBLES(1)) r1 ();

  logic [3:0] dp_a4, dp_b4, dp_sum4, dp_a1, dp_b1, dp_sum1;
  logic       dp_cin4, dp_cout4, dp_cin1, dp_cout1;
  logic [4:0] full4, full1;

  assign full4    = {1'b0, dp_a4} + {1'b0, dp_b4 ^ {4{dp_cin4}}} + {4'h0, dp_cin4};
  assign dp_sum4  = full4[3:0];
  assign dp_cout4 = full4[4];
  assign full1    = {1'b0, dp_a1} + {1'b0, dp_b1 ^ {4{dp_cin1}}} + {4'h0, dp_cin1};
  assign dp_sum1  = full1[3:0];
  assign dp_cout1 = full1[4];

  addsub_nibble_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(r4.slave),
    .dp_a(dp_a4), .dp_b(dp_b4), .dp_cin(dp_cin4), .dp_sum(dp_sum4), .dp_cout(dp_cout4)
  );

  addsub_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(r1.slave),
    .dp_a(dp_a1), .dp_b(dp_b1), .dp_cin(dp_cin1), .dp_sum(dp_sum1), .dp_cout(dp_cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge on the 4-nibble instance; returns just after acceptance.
  task automatic start_req4(input logic op, input logic [15:0] a, input logic [15:0] b);
    r4.start = 1'b1;
    r4.op    = op;
    r4.a     = a;
    r4.b     = b;
    step();
    r4.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    r4.start = 1'b0; r4.op = 1'b0; r4.a = '0; r4.b = '0;
    r1.start = 1'b0; r1.op = 1'b0; r1.a = '0; r1.b = '0;
    #3;
    checks++;
    if ({r4.busy, r4.done, r4.result, r4.cout, r4.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs4 got %h want 0",
               {r4.busy, r4.done, r4.result, r4.cout, r4.ovf});
    end
    checks++;
    if ({dp_a4, dp_b4, dp_cin4} !== 9'h0) begin
      errors++;
      $display("FAIL reset_dp4 got %h want 0", {dp_a4, dp_b4, dp_cin4});
    end
    checks++;
    if ({r1.busy, r1.done, r1.result, r1.cout, r1.ovf} !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs1 got %h want 0",
               {r1.busy, r1.done, r1.result, r1.cout, r1.ovf});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    start_req4(1'b0, 16'h1234, 16'h0FCD);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r4.busy !== 1'b1 || r4.done !== 1'b0) begin
        errors++;
        $display("FAIL add_busy cycle %0d got busy=%b done=%b want 1 0", i, r4.busy, r4.done);
      end
      step();
    end
    checks++;
    if (r4.done !== 1'b1 || r4.busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done got done=%b busy=%b want 1 0", r4.done, r4.busy);
    end
    checks++;
    if ({r4.result, r4.cout, r4.ovf} !== {16'h2201, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_result got %h c%b v%b want 2201 c0 v0", r4.result, r4.cout, r4.ovf);
    end
    step();
    checks++;
    if (r4.done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse got done=%b want 0", r4.done);
    end
    checks++;
    if ({dp_a4, dp_b4, dp_cin4} !== 9'h0) begin
      errors++;
      $display("FAIL idle_dp got %h want 0", {dp_a4, dp_b4, dp_cin4});
    end
  endtask

  task automatic test_sub_chain();
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    logic       exp_c [4];
    exp_a = '{4'h5, 4'h0, 4'h0, 4'h0};
    exp_b = '{4'h7, 4'hF, 4'hF, 4'hF};
    exp_c = '{1'b1, 1'b0, 1'b0, 1'b0};
    start_req4(1'b1, 16'h0005, 16'h0007);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dp_a4 !== exp_a[i] || dp_b4 !== exp_b[i] || dp_cin4 !== exp_c[i]) begin
        errors++;
        $display("FAIL sub_nibble %0d got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                 i, dp_a4, dp_b4, dp_cin4, exp_a[i], exp_b[i], exp_c[i]);
      end
      checks++;
      if (r4.result !== 16'h2201) begin
        errors++;
        $display("FAIL sub_result_hold %0d got %h want 2201", i, r4.result);
      end
      step();
    end
    checks++;
    if (r4.done !== 1'b1 || {r4.result, r4.cout, r4.ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_result got done=%b %h c%b v%b want 1 FFFE c0 v0",
               r4.done, r4.result, r4.cout, r4.ovf);
    end
    step();
  endtask

  task automatic test_overflow();
    logic        ops  [2];
    logic [15:0] as   [2];
    logic [15:0] bs   [2];
    logic [17:0] exps [2];
    ops  = '{1'b0, 1'b1};
    as   = '{16'h7FFF, 16'h8000};
    bs   = '{16'h0001, 16'h0001};
    exps = '{{16'h8000, 1'b0, 1'b1}, {16'h7FFF, 1'b1, 1'b1}};
    for (int k = 0; k < 2; k++) begin
      start_req4(ops[k], as[k], bs[k]);
      repeat (4) step();
      checks++;
      if (r4.done !== 1'b1 || {r4.result, r4.cout, r4.ovf} !== exps[k]) begin
        errors++;
        $display("FAIL ovf_case %0d got done=%b %h want 1 %h",
                 k, r4.done, {r4.result, r4.cout, r4.ovf}, exps[k]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    start_req4(1'b0, 16'hFFFF, 16'h0001);
    step();
    // Ignored start while busy, with different operands.
    r4.start = 1'b1; r4.op = 1'b1; r4.a = 16'h1111; r4.b = 16'h2222;
    step();
    r4.start = 1'b0;
    r4.a = 16'hAAAA; r4.b = 16'h5555;
    for (int i = 0; i < 6 && r4.done !== 1'b1; i++) step();
    checks++;
    if (r4.done !== 1'b1 || {r4.result, r4.cout} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got done=%b %h c%b want 1 0000 c1",
               r4.done, r4.result, r4.cout);
    end
    // New request in the done cycle.
    start_req4(1'b0, 16'h1234, 16'h0FCD);
    checks++;
    if (r4.done !== 1'b0 || r4.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got done=%b busy=%b want 0 1", r4.done, r4.busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (r4.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || r4.done !== 1'b1 || r4.result !== 16'h2201) begin
      errors++;
      $display("FAIL b2b_second got dones=%0d done=%b %h want 1 1 2201",
               dones, r4.done, r4.result);
    end
    step();
  endtask

  task automatic test_async_reset();
    int dones;
    dones = 0;
    start_req4(1'b0, 16'h0001, 16'h0001);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({r4.busy, r4.done, r4.result, r4.cout, r4.ovf} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {r4.busy, r4.done, r4.result, r4.cout, r4.ovf});
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (r4.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || r4.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_no_done got dones=%0d busy=%b want 0 0", dones, r4.busy);
    end
    start_req4(1'b0, 16'h7FFF, 16'h0001);
    repeat (4) step();
    checks++;
    if (r4.done !== 1'b1 || {r4.result, r4.cout, r4.ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_recover got done=%b %h c%b v%b want 1 8000 c0 v1",
               r4.done, r4.result, r4.cout, r4.ovf);
    end
    step();
  endtask

  task automatic test_nibbles1();
    r1.start = 1'b1; r1.op = 1'b1; r1.a = 4'h3; r1.b = 4'h5;
    step();
    r1.start = 1'b0;
    checks++;
    if (r1.busy !== 1'b1 || r1.done !== 1'b0 || dp_b1 !== 4'h5 || dp_cin1 !== 1'b1) begin
      errors++;
      $display("FAIL n1_run got busy=%b done=%b dp_b=%h cin=%b want 1 0 5 1",
               r1.busy, r1.done, dp_b1, dp_cin1);
    end
    step();
    checks++;
    if (r1.done !== 1'b1 || {r1.result, r1.cout, r1.ovf} !== {4'hE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL n1_result got done=%b %h c%b v%b want 1 E c0 v0",
               r1.done, r1.result, r1.cout, r1.ovf);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub_chain();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_nibbles1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
